// File: rtl/shift_serializer_sar.sv
// Parallel-to-serial converter with valid/ready input handshake.
// Optional even-parity bit per frame, enabled by defining SHIFT_SER_PARITY_EN.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   in_valid   - a word is offered on in_data
//   in_ready   - the block accepts a word this cycle (IDLE or final bit cycle)
//   in_data    - WIDTH-bit parallel word
//   dir        - 0 = MSB-first, 1 = LSB-first (captured on acceptance)
//   ser_out    - serial data / parity bit
//   ser_valid  - ser_out carries a data or parity bit
//   mod_out    - downstream shift-mode code: 00 shift MSB-first, 01 LSB-first, 11 hold
//   frame_done - one-cycle pulse on the last bit of a frame
module shift_serializer_sar #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             dir,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [1:0]       mod_out,
    output logic             frame_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef SHIFT_SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t             state;
    state_t             nxt_state;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   nxt_sreg;
    logic [WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   nxt_cnt;
    logic               dir_q;
    logic               nxt_dir;
    logic               nxt_ser_out;
    logic               nxt_ser_valid;
    logic               nxt_last;
    logic               accept;
`ifdef SHIFT_SER_PARITY_EN
    logic               par_q;
    logic               nxt_par;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state, datapath and registered-output next values
    always_comb begin
        nxt_state     = state;
        nxt_sreg      = sreg;
        nxt_cnt       = cnt;
        nxt_dir       = dir_q;
        nxt_ser_out   = 1'b0;
        nxt_ser_valid = 1'b0;
        nxt_last      = 1'b0;
`ifdef SHIFT_SER_PARITY_EN
        nxt_par       = par_q;
`endif
        accept  = in_valid && in_ready;
        shifted = dir_q ? (sreg >> 1) : (sreg << 1);

        // in_ready is only high in IDLE or the final bit cycle, so an
        // acceptance always starts a fresh frame regardless of state.
        if (accept) begin
            nxt_state     = SHIFT;
            nxt_sreg      = in_data;
            nxt_cnt       = CNT_W'(WIDTH - 1);
            nxt_dir       = dir;
            nxt_ser_out   = dir ? in_data[0] : in_data[WIDTH-1];
            nxt_ser_valid = 1'b1;
`ifdef SHIFT_SER_PARITY_EN
            nxt_par       = ^in_data;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt != '0) begin
                        nxt_sreg      = shifted;
                        nxt_cnt       = cnt - CNT_W'(1);
                        nxt_ser_out   = dir_q ? shifted[0] : shifted[WIDTH-1];
                        nxt_ser_valid = 1'b1;
                    end else begin
`ifdef SHIFT_SER_PARITY_EN
                        nxt_state     = PARITY;
                        nxt_ser_out   = par_q;
                        nxt_ser_valid = 1'b1;
`else
                        nxt_state     = IDLE;
`endif
                    end
                end
`ifdef SHIFT_SER_PARITY_EN
                PARITY: nxt_state = IDLE;
`endif
                default: nxt_state = IDLE;
            endcase
        end

        // Final bit cycle of a frame: last data bit, or the parity bit
`ifdef SHIFT_SER_PARITY_EN
        nxt_last = (nxt_state == PARITY);
`else
        nxt_last = (nxt_state == SHIFT) && (nxt_cnt == '0);
`endif
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            cnt        <= '0;
            dir_q      <= 1'b0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            mod_out    <= 2'b11;
            frame_done <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            sreg       <= nxt_sreg;
            cnt        <= nxt_cnt;
            dir_q      <= nxt_dir;
            ser_out    <= nxt_ser_out;
            ser_valid  <= nxt_ser_valid;
            mod_out    <= nxt_ser_valid ? {1'b0, nxt_dir} : 2'b11;
            frame_done <= nxt_last;
            in_ready   <= (nxt_state == IDLE) || nxt_last;
        end
    end

`ifdef SHIFT_SER_PARITY_EN
    // Parity of the captured word, sent after the last data bit
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= nxt_par;
        end
    end
`endif

endmodule

// File: tb/tb_shift_serializer_sar.sv
// Directed self-checking bench for shift_serializer_sar (WIDTH = 16).
module tb_shift_serializer_sar;

    localparam int unsigned WIDTH = 16;
`ifdef SHIFT_SER_PARITY_EN
    localparam int FLEN = 17;
`else
    localparam int FLEN = 16;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             dir;
    logic             ser_out;
    logic             ser_valid;
    logic [1:0]       mod_out;
    logic             frame_done;

    int checks = 0;
    int errors = 0;

    shift_serializer_sar #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .dir        (dir),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .mod_out    (mod_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; dir = 1'b0;
        step(); step();
        checks++;
        if ({in_ready, ser_valid, ser_out, mod_out, frame_done} !== 6'b1_0_0_11_0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b out=%b mod=%b fd=%b exp rdy=1 vld=0 out=0 mod=11 fd=0",
                     in_ready, ser_valid, ser_out, mod_out, frame_done);
        end
        // valid was high during reset; only a held valid starts a frame
        in_valid = 1'b0; rst = 1'b0;
        step();
        checks++;
        if (ser_valid !== 1'b0 || mod_out !== 2'b11) begin
            errors++;
            $display("FAIL reset_valid_ignored got vld=%b mod=%b exp vld=0 mod=11", ser_valid, mod_out);
        end
        step(); step();
        checks++;
        if (ser_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_stays got vld=%b rdy=%b exp vld=0 rdy=1", ser_valid, in_ready);
        end
    endtask

    task automatic test_msb_first();
        logic [15:0] stream;
        stream = 16'b1010_0101_1100_0011;
        in_data = 16'hA5C3; dir = 1'b0; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_pre_accept got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, ser_valid);
        end
        step();
        in_valid = 1'b0; in_data = 16'h0000;
        for (int i = 0; i < FLEN; i++) begin
            checks++;
            if (ser_valid !== 1'b1 || mod_out !== 2'b00 ||
                frame_done !== (i == FLEN - 1) || in_ready !== (i == FLEN - 1)) begin
                errors++;
                $display("FAIL msb_ctrl bit %0d got vld=%b mod=%b fd=%b rdy=%b exp vld=1 mod=00 fd=%b rdy=%b",
                         i, ser_valid, mod_out, frame_done, in_ready, i == FLEN - 1, i == FLEN - 1);
            end
            if (i < 16) begin
                checks++;
                if (ser_out !== stream[15 - i]) begin
                    errors++;
                    $display("FAIL msb_data bit %0d got %b exp %b", i, ser_out, stream[15 - i]);
                end
            end
            step();
        end
        checks++;
        if ({in_ready, ser_valid, ser_out, mod_out, frame_done} !== 6'b1_0_0_11_0) begin
            errors++;
            $display("FAIL msb_return_idle got rdy=%b vld=%b out=%b mod=%b fd=%b exp 1 0 0 11 0",
                     in_ready, ser_valid, ser_out, mod_out, frame_done);
        end
    endtask

    task automatic test_lsb_first_dir_toggle();
        in_data = 16'h0001; dir = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            if (i == 3) dir = 1'b0;
            if (i == 9) dir = 1'b1;
            checks++;
            if (ser_valid !== 1'b1 || mod_out !== 2'b01 || frame_done !== (i == FLEN - 1)) begin
                errors++;
                $display("FAIL lsb_ctrl bit %0d got vld=%b mod=%b fd=%b exp vld=1 mod=01 fd=%b",
                         i, ser_valid, mod_out, frame_done, i == FLEN - 1);
            end
            if (i < 16) begin
                checks++;
                if (ser_out !== (i == 0)) begin
                    errors++;
                    $display("FAIL lsb_data bit %0d got %b exp %b", i, ser_out, i == 0);
                end
            end
            step();
        end
        checks++;
        if (ser_valid !== 1'b0 || mod_out !== 2'b11) begin
            errors++;
            $display("FAIL lsb_return_idle got vld=%b mod=%b exp vld=0 mod=11", ser_valid, mod_out);
        end
        dir = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_bit;
        in_data = 16'hFFFF; dir = 1'b0; in_valid = 1'b1;
        step();
        // offered while in_ready is low; must only be taken on the final bit
        in_data = 16'h0000;
        for (int i = 0; i < 2 * FLEN; i++) begin
            if (i == FLEN) in_valid = 1'b0;
            exp_bit = ((i % FLEN) < 16) ? (i < FLEN) : 1'b0;
            checks++;
            if (ser_valid !== 1'b1 || ser_out !== exp_bit ||
                in_ready !== ((i % FLEN) == FLEN - 1) || frame_done !== ((i % FLEN) == FLEN - 1)) begin
                errors++;
                $display("FAIL b2b cycle %0d got vld=%b out=%b rdy=%b fd=%b exp vld=1 out=%b rdy=%b fd=%b",
                         i, ser_valid, ser_out, in_ready, frame_done, exp_bit,
                         (i % FLEN) == FLEN - 1, (i % FLEN) == FLEN - 1);
            end
            step();
        end
        checks++;
        if (ser_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_return_idle got vld=%b rdy=%b exp vld=0 rdy=1", ser_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] stream;
        stream = 16'b0001_0010_0011_0100;
        in_data = 16'h1234; dir = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ser_out !== stream[15 - i] || ser_valid !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_data bit %0d got out=%b vld=%b exp out=%b vld=1",
                         i, ser_out, ser_valid, stream[15 - i]);
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({in_ready, ser_valid, ser_out, mod_out, frame_done} !== 6'b1_0_0_11_0) begin
            errors++;
            $display("FAIL rstmid_abort got rdy=%b vld=%b out=%b mod=%b fd=%b exp 1 0 0 11 0",
                     in_ready, ser_valid, ser_out, mod_out, frame_done);
        end
        for (int i = 0; i < FLEN; i++) begin
            step();
            checks++;
            if (frame_done !== 1'b0 || ser_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_done cycle %0d got fd=%b vld=%b exp fd=0 vld=0",
                         i, frame_done, ser_valid);
            end
        end
    endtask

`ifdef SHIFT_SER_PARITY_EN
    task automatic test_parity();
        logic [15:0] words [2];
        logic        pars  [2];
        words[0] = 16'h0007; pars[0] = 1'b1;
        words[1] = 16'h0003; pars[1] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            in_data = words[w]; dir = 1'b0; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (ser_out !== ((i < 16) ? words[w][15 - i] : pars[w]) ||
                    ser_valid !== 1'b1 || mod_out !== 2'b00 || frame_done !== (i == 16)) begin
                    errors++;
                    $display("FAIL parity word %0d bit %0d got out=%b vld=%b mod=%b fd=%b exp out=%b fd=%b",
                             w, i, ser_out, ser_valid, mod_out, frame_done,
                             (i < 16) ? words[w][15 - i] : pars[w], i == 16);
                end
                step();
            end
            checks++;
            if (ser_valid !== 1'b0 || mod_out !== 2'b11) begin
                errors++;
                $display("FAIL parity_idle word %0d got vld=%b mod=%b exp vld=0 mod=11",
                         w, ser_valid, mod_out);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; dir = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first_dir_toggle();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SHIFT_SER_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
